register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of each register and of the data ports.
REQ-002 Parameter ADDR_WIDTH, default 4; register index width, giving 2^ADDR_WIDTH = 16 registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 CLK  input  1  clock; all state changes on the rising edge, except reset.
REQ-005 RST  input  1  asynchronous active-low reset; 0 clears the array.
REQ-006 in_RegWrite  input  1  write enable, sampled on the rising edge of CLK.
REQ-007 in_ReadReg1  input  ADDR_WIDTH  read port 1 address.
REQ-008 in_ReadReg2  input  ADDR_WIDTH  read port 2 address.
REQ-009 in_WriteAddr  input  ADDR_WIDTH  write port address.
REQ-010 in_Data  input  DATA_WIDTH  write data.
REQ-011 out_ReadData1  output  DATA_WIDTH  contents of register in_ReadReg1.
REQ-012 out_ReadData2  output  DATA_WIDTH  contents of register in_ReadReg2.

Function
REQ-013 SHALL hold 16 registers x0..x15, each DATA_WIDTH bits, with no sign interpretation; all bits are stored verbatim.
REQ-014 Reads SHALL be combinational with zero-cycle latency; each output follows its address and the stored contents within the same cycle.
REQ-015 The two read ports SHALL be fully independent and may address the same register, including the register being written.
REQ-016 On the rising CLK edge with RST=1 and in_RegWrite=1, register in_WriteAddr SHALL load in_Data; the new value is visible on the read ports after that edge.
REQ-017 With in_RegWrite=0, no register SHALL change.
REQ-018 Register x0 SHALL always read 0; writes to address 0 SHALL be ignored with no error indication.
REQ-019 Read-during-write to the same address with REGFILE_BYPASS_EN undefined: the output SHALL show the old value until the edge and the new value after it.
REQ-020 Exactly one register SHALL be written per edge; there are no partial or byte writes.

Reset
REQ-021 RST=0 SHALL asynchronously clear x1..x15 to 0, with no clock required.
REQ-022 While RST=0, both outputs SHALL read 0 for every address, and writes SHALL be ignored.
REQ-023 A write presented on the same edge on which RST is sampled low SHALL be discarded.
REQ-024 After RST returns to 1, the first rising edge with in_RegWrite=1 SHALL perform a normal write.
REQ-025 Reset asserted mid-operation SHALL override any pending write.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
REQ-027 When REGFILE_BYPASS_EN is defined, and in_RegWrite=1, RST=1 and in_WriteAddr equals a nonzero read address, that read port SHALL output in_Data combinationally in the same cycle.
REQ-028 When REGFILE_BYPASS_EN is defined, address 0 SHALL still read 0.
REQ-029 When REGFILE_BYPASS_EN is undefined, no forwarding logic SHALL exist and REQ-019 applies.

Verification
REQ-030 Positive write: RST=1, in_RegWrite=1, in_WriteAddr=1, in_Data=0x0001, one edge; then in_RegWrite=0, in_ReadReg1=1 -> out_ReadData1=0x0001.
REQ-031 MSB-set write: write 0x8001 to x2, then in_ReadReg2=2 -> out_ReadData2=0x8001, with all 16 bits preserved.
REQ-032 Reset: with x1=0x0001 and x2=0x8001 stored, drive RST=0 with no clock edge -> out_ReadData1=0 and out_ReadData2=0 immediately; after release both still read 0.
REQ-033 x0 write: in_WriteAddr=0, in_Data=0x0001, in_RegWrite=1, one edge -> out_ReadData1=0 for in_ReadReg1=0.
REQ-034 Dual-port/disabled write: write 0x1234 to x5 and 0xBEEF to x9; set in_ReadReg1=5, in_ReadReg2=9 -> outputs 0x1234 and 0xBEEF; then in_RegWrite=0 with in_Data=0xFFFF at x5 -> x5 stays 0x1234.
REQ-035 Read-during-write on x3 (old value 0x0011, new value 0x00AA): with REGFILE_BYPASS_EN defined, 0x00AA appears before the edge; with it undefined, 0x0011 shows before the edge and 0x00AA after it.

Source files
------------

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file access bus: one write port, two read ports
interface register_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_RegWrite;
    logic [ADDR_WIDTH-1:0] in_ReadReg1;
    logic [ADDR_WIDTH-1:0] in_ReadReg2;
    logic [ADDR_WIDTH-1:0] in_WriteAddr;
    logic [DATA_WIDTH-1:0] in_Data;
    logic [DATA_WIDTH-1:0] out_ReadData1;
    logic [DATA_WIDTH-1:0] out_ReadData2;

    modport master (
        output in_RegWrite,
        output in_ReadReg1,
        output in_ReadReg2,
        output in_WriteAddr,
        output in_Data,
        input  out_ReadData1,
        input  out_ReadData2
    );

    modport slave (
        input  in_RegWrite,
        input  in_ReadReg1,
        input  in_ReadReg2,
        input  in_WriteAddr,
        input  in_Data,
        output out_ReadData1,
        output out_ReadData2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file, x0 hardwired to zero, optional REGFILE_BYPASS_EN forwarding
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    register_file_if.slave      rf
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    // Entry 0 is never loaded, so it stays at its reset value; reads of
    // address 0 are also forced to zero so x0 is zero by construction.
    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];

    logic write_en;
    assign write_en = rf.in_RegWrite && (rf.in_WriteAddr != '0);

    // Next-state of the array: only the addressed nonzero entry changes.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_en) begin
            regs_d[rf.in_WriteAddr] = rf.in_Data;
        end
    end

    // Array storage; asynchronous reset clears every entry and holds it clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports; RST is only seen by the forwarding path,
    // because the array itself already reads zero while reset is held.
    always_comb begin
        rf.out_ReadData1 = '0;
        rf.out_ReadData2 = '0;
        if (rf.in_ReadReg1 != '0) begin
            rf.out_ReadData1 = regs_q[rf.in_ReadReg1];
        end
        if (rf.in_ReadReg2 != '0) begin
            rf.out_ReadData2 = regs_q[rf.in_ReadReg2];
        end
`ifdef REGFILE_BYPASS_EN
        if (RST && write_en && (rf.in_WriteAddr == rf.in_ReadReg1)) begin
            rf.out_ReadData1 = rf.in_Data;
        end
        if (RST && write_en && (rf.in_WriteAddr == rf.in_ReadReg2)) begin
            rf.out_ReadData2 = rf.in_Data;
        end
`endif
    end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .rf  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data);
        @(negedge CLK);
        bus.in_RegWrite  = 1'b1;
        bus.in_WriteAddr = addr;
        bus.in_Data      = data;
        @(posedge CLK);
        #1;
        bus.in_RegWrite  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        bus.in_ReadReg1 = a1;
        bus.in_ReadReg2 = a2;
        #1;
    endtask

    initial begin
        bus.in_RegWrite  = 1'b0;
        bus.in_ReadReg1  = 4'd3;
        bus.in_ReadReg2  = 4'd7;
        bus.in_WriteAddr = 4'd0;
        bus.in_Data      = 16'h0000;
        #12;
        check("reset_rd1", bus.out_ReadData1, 16'h0000);
        check("reset_rd2", bus.out_ReadData2, 16'h0000);
        @(negedge CLK);
        RST = 1'b1;

        // basic writes, including MSB-set value
        wr(4'd1, 16'h0001);
        rd(4'd1, 4'd0);
        check("x1_write", bus.out_ReadData1, 16'h0001);
        check("x0_port2", bus.out_ReadData2, 16'h0000);
        wr(4'd2, 16'h8001);
        rd(4'd1, 4'd2);
        check("x2_msb", bus.out_ReadData2, 16'h8001);
        check("x1_kept", bus.out_ReadData1, 16'h0001);
        rd(4'd2, 4'd2);
        check("same_reg_p1", bus.out_ReadData1, 16'h8001);
        check("same_reg_p2", bus.out_ReadData2, 16'h8001);

        // asynchronous reset mid-cycle, no clock edge needed
        @(negedge CLK);
        #2;
        rd(4'd1, 4'd2);
        RST = 1'b0;
        #1;
        check("async_rst_x1", bus.out_ReadData1, 16'h0000);
        check("async_rst_x2", bus.out_ReadData2, 16'h0000);
        for (int a = 3; a < 16; a++) begin
            rd(a[3:0], a[3:0]);
            check("rst_all_addr", bus.out_ReadData1, 16'h0000);
        end
        // write attempted while reset is held is discarded
        @(negedge CLK);
        bus.in_RegWrite  = 1'b1;
        bus.in_WriteAddr = 4'd4;
        bus.in_Data      = 16'h5555;
        bus.in_ReadReg1  = 4'd4;
        #1;
        check("rst_no_fwd", bus.out_ReadData1, 16'h0000);
        @(posedge CLK);
        #1;
        check("rst_wr_ignored", bus.out_ReadData1, 16'h0000);
        @(negedge CLK);
        bus.in_RegWrite = 1'b0;
        RST = 1'b1;
        rd(4'd1, 4'd2);
        check("post_rst_x1", bus.out_ReadData1, 16'h0000);
        check("post_rst_x2", bus.out_ReadData2, 16'h0000);
        rd(4'd4, 4'd0);
        check("post_rst_x4", bus.out_ReadData1, 16'h0000);
        wr(4'd4, 16'h0042);
        rd(4'd4, 4'd0);
        check("first_wr_after_rst", bus.out_ReadData1, 16'h0042);

        // x0 write ignored
        wr(4'd0, 16'h0001);
        rd(4'd0, 4'd0);
        check("x0_write_ignored", bus.out_ReadData1, 16'h0000);

        // dual port and disabled write
        wr(4'd5, 16'h1234);
        wr(4'd9, 16'hBEEF);
        rd(4'd5, 4'd9);
        check("dual_x5", bus.out_ReadData1, 16'h1234);
        check("dual_x9", bus.out_ReadData2, 16'hBEEF);
        @(negedge CLK);
        bus.in_RegWrite  = 1'b0;
        bus.in_WriteAddr = 4'd5;
        bus.in_Data      = 16'hFFFF;
        @(posedge CLK);
        #1;
        check("we0_x5_kept", bus.out_ReadData1, 16'h1234);

        // top-of-range register
        wr(4'd15, 16'hFFFF);
        rd(4'd15, 4'd9);
        check("x15_all_ones", bus.out_ReadData1, 16'hFFFF);
        check("x9_kept", bus.out_ReadData2, 16'hBEEF);

        // read-during-write on x3
        wr(4'd3, 16'h0011);
        @(negedge CLK);
        bus.in_ReadReg1  = 4'd3;
        bus.in_ReadReg2  = 4'd5;
        bus.in_RegWrite  = 1'b1;
        bus.in_WriteAddr = 4'd3;
        bus.in_Data      = 16'h00AA;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", bus.out_ReadData1, 16'h00AA);
`else
        check("rdw_before_edge", bus.out_ReadData1, 16'h0011);
`endif
        check("rdw_other_port", bus.out_ReadData2, 16'h1234);
        @(posedge CLK);
        #1;
        bus.in_RegWrite = 1'b0;
        #1;
        check("rdw_after_edge", bus.out_ReadData1, 16'h00AA);

        // write to x0 with read of x0 in the same cycle never forwards
        @(negedge CLK);
        bus.in_RegWrite  = 1'b1;
        bus.in_WriteAddr = 4'd0;
        bus.in_Data      = 16'hFFFF;
        bus.in_ReadReg1  = 4'd0;
        bus.in_ReadReg2  = 4'd0;
        #1;
        check("x0_no_fwd_p1", bus.out_ReadData1, 16'h0000);
        check("x0_no_fwd_p2", bus.out_ReadData2, 16'h0000);
        @(posedge CLK);
        #1;
        bus.in_RegWrite = 1'b0;
        #1;
        check("x0_after_edge", bus.out_ReadData1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
